hazard_unit: RTL

- Source of the stall/flush controls consumed by the ID/EX register (`hazard`, `branchControlEx`), PC and IF/ID write enables.
- Keeps its own shadow record of the destination register for each instruction in EX and MEM.
- Detects load-use RAW hazards against the instruction in ID and inserts one bubble per hazard cycle.
- Turns a taken branch in EX into a two-stage flush; counts stall and flush cycles for performance debug.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_sat_counter.sv | 19 +
 rtl/hazard_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard unit: shadow slot record,
// register-zero constant and the RAW match test.
package hazard_pkg;

  localparam int unsigned SLOT_AW = 5;

  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_read;
    logic [SLOT_AW-1:0] dest;
  } shadow_slot_t;

  localparam logic [SLOT_AW-1:0] REG_ZERO    = '0;
  localparam shadow_slot_t       BUBBLE_SLOT = '0;

  // True when the ID instruction reads the (non-zero) register a slot will write.
  function automatic logic slot_match(input shadow_slot_t slot,
                                      input logic uses_rs, input logic [SLOT_AW-1:0] rs,
                                      input logic uses_rt, input logic [SLOT_AW-1:0] rt);
    return slot.valid && (slot.dest != REG_ZERO) &&
           ((uses_rs && (rs == slot.dest)) || (uses_rt && (rt == slot.dest)));
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module hazard_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Load-use / branch-flush hazard control with shadow EX/MEM destination tracking.
// Define HAZARD_FULL_INTERLOCK_EN to also stall on any EX/MEM RAW dependence.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned REG_AW = SLOT_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              idValid,
  input  logic [REG_AW-1:0] idRs,
  input  logic [REG_AW-1:0] idRt,
  input  logic              idUsesRs,
  input  logic              idUsesRt,
  input  logic              idRegWrite,
  input  logic              idMemRead,
  input  logic [REG_AW-1:0] idDest,
  input  logic              branchTakenEx,
  output logic              hazard,
  output logic              branchControlEx,
  output logic              flushIfId,
  output logic              pcWrite,
  output logic              ifIdWrite,
  output logic [CNT_W-1:0]  stallCycles,
  output logic [CNT_W-1:0]  flushCycles
);

  shadow_slot_t       ex_slot;
  shadow_slot_t       mem_slot;
  logic [SLOT_AW-1:0] rs;
  logic [SLOT_AW-1:0] rt;
  logic               ex_match;
  logic               mem_match;
  logic               stall_c;

  assign rs        = SLOT_AW'(idRs);
  assign rt        = SLOT_AW'(idRt);
  assign ex_match  = slot_match(ex_slot,  idUsesRs, rs, idUsesRt, rt);
  assign mem_match = slot_match(mem_slot, idUsesRs, rs, idUsesRt, rt);

`ifdef HAZARD_FULL_INTERLOCK_EN
  // Without forwarding every pending EX/MEM write must drain before ID reads it.
  assign stall_c = idValid && ((ex_slot.mem_read  && ex_match) ||
                               (ex_slot.reg_write && ex_match) ||
                               (mem_slot.reg_write && mem_match));
`else
  logic mem_match_unused;
  assign mem_match_unused = mem_match;
  assign stall_c = idValid && ex_slot.mem_read && ex_match;
`endif

  // Branch beats load-use: the ID instruction is squashed, so no stall is needed.
  always_comb begin
    hazard          = 1'b0;
    branchControlEx = 1'b0;
    flushIfId       = 1'b0;
    pcWrite         = 1'b0;
    ifIdWrite       = 1'b0;
    if (!reset) begin
      if (branchTakenEx) begin
        branchControlEx = 1'b1;
        flushIfId       = 1'b1;
        pcWrite         = 1'b1;
        ifIdWrite       = 1'b1;
      end else if (stall_c) begin
        hazard = 1'b1;
      end else begin
        pcWrite   = 1'b1;
        ifIdWrite = 1'b1;
      end
    end
  end

  // Shadow of the destinations travelling through EX and MEM.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_slot  <= BUBBLE_SLOT;
      mem_slot <= BUBBLE_SLOT;
    end else begin
      mem_slot <= ex_slot;
      if (hazard || branchControlEx || !idValid) begin
        ex_slot <= BUBBLE_SLOT;
      end else begin
        ex_slot <= '{valid: 1'b1, reg_write: idRegWrite, mem_read: idMemRead,
                     dest: SLOT_AW'(idDest)};
      end
    end
  end

  hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hazard),
    .count (stallCycles)
  );

  hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (branchControlEx),
    .count (flushCycles)
  );

endmodule
